mem_bus_arbiter: RTL
====================

// Module: mem_bus_arbiter
// PURPOSE
//  Two-master, one-slave arbiter that shares the SoC's single-port memory between the
//  core's instruction-fetch port (m0) and its load/store port (m1).
//  It grants one request per cycle and tracks the one-cycle-latency response, routing it
//  back to the master that issued the request.
//  It sits between the core top and the rom/ram block inside riscv_soc.
// PARAMETERS
//  ADDR_W      32  address width, all ports
//  DATA_W      32  data width, all ports
//  PRIO_MODE   0   0 = round-robin; 1 = fixed m0 priority with starvation guard
//  MAX_WAIT    4   PRIO_MODE=1 only: consecutive m1 wait cycles before m1 is forced
// PORTS
//  clk         in   1         clock, all state on rising edge
//  rst_n       in   1         asynchronous active-low reset
//  m0_req      in   1         fetch request, held until granted
//  m0_addr     in   ADDR_W    fetch address
//  m0_gnt      out  1         fetch request accepted this cycle
//  m0_rvalid   out  1         fetch response valid (cycle after m0_gnt)
//  m1_req      in   1         load/store request, held until granted
//  m1_we       in   1         1 = write, 0 = read
//  m1_addr     in   ADDR_W    load/store address
//  m1_wdata    in   DATA_W    write data
//  m1_be       in   DATA_W/8  write byte enables
//  m1_gnt      out  1         load/store request accepted this cycle
//  m1_rvalid   out  1         response/write-ack valid (cycle after m1_gnt)
//  m_rdata     out  DATA_W    response data to both masters; qualified by mX_rvalid
//  s_req       out  1         request to memory
//  s_we        out  1         write strobe to memory
//  s_addr      out  ADDR_W    memory address
//  s_wdata     out  DATA_W    memory write data
//  s_be        out  DATA_W/8  memory byte enables (all ones for m0)
//  s_ready     in   1         memory can accept a request this cycle
//  s_rdata     in   DATA_W    memory read data, valid the cycle after acceptance
// BEHAVIOUR
//  - Reset state: rst_n low forces every gnt, rvalid and s_req to 0 and s_we to 0.
//    Reset also sets last_owner=m1, so m0 wins first in round-robin.
//    It clears the pending response and the starvation counter.
//  - Grant (combinational from req, s_ready and registered state).
//    - No grant and s_req=0 when s_ready=0 or no req.
//    - One request only: that master is granted.
//    - Both requesting, PRIO_MODE=0: grant the master that is not last_owner.
//    - Both requesting, PRIO_MODE=1: grant m0 unless wait_cnt>=MAX_WAIT, then grant m1.
//    - At most one gnt high per cycle. s_* is muxed from the granted master.
//      When nothing is granted, s_* holds 0.
//  - Registered state on each grant:
//    - last_owner <= granted master
//    - resp_pend <= 1
//    - resp_owner <= granted master
//    - A cycle with no grant clears resp_pend.
//  - Response, latency 1:
//    - mX_rvalid = resp_pend && resp_owner==X; writes also get rvalid (ack).
//    - m_rdata = s_rdata unmodified; its value for writes is don't-care.
//    - Back-to-back grants give back-to-back rvalids, with no bubble.
//  - Starvation counter (PRIO_MODE=1):
//    - wait_cnt increments when m1_req=1 and m1 is not granted.
//    - It saturates at MAX_WAIT and clears to 0 when m1 is granted or m1_req=0.
//  - Stall: with s_ready=0, requests stay pending and no state changes.
//    A response already pending still completes that cycle.
//  - Reset mid-transaction: the pending response is dropped; no rvalid after rst_n rises.
//  - Masters must hold req/addr/wdata stable until their gnt.
//    The arbiter does not register request payload.
// TESTING
//  - Reset: assert rst_n=0 with both reqs high.
//    -> all gnt/rvalid/s_req 0; after release, first grant goes to m0.
//  - Single master: m0_req for 3 cycles at addr 0x0,0x4,0x8.
//    -> m0_gnt 3 cycles; m0_rvalid 3 cycles, each one cycle later with matching rdata.
//  - RR contention: PRIO_MODE=0, both req for 4 cycles.
//    -> grants m0,m1,m0,m1; each rvalid routed to the right master.
//  - Starvation: PRIO_MODE=1, MAX_WAIT=4, both req continuously.
//    -> m0 x4, then m1 granted on 5th cycle, then counter 0 and m0 resumes.
//  - Stall: s_ready=0 for 3 cycles during contention.
//    -> no gnt, no s_req; pending rvalid from prior grant still delivered; order kept.
//  - Write then read: m1 writes 0xDEADBEEF, be=4'b1111 at 0x100, then reads 0x100.
//    -> write ack rvalid; read rvalid with rdata 0xDEADBEEF.
//    -> rst_n pulse between grant and response yields no rvalid.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares the single-port memory between two masters: the instruction-fetch port (m0) and
// the load/store port (m1). The arbiter grants at most one request per cycle. It tracks
// the one-cycle-latency response and routes it back to the master that issued the request.
//
// Ports
//   clk, rst_n                clock and asynchronous active-low reset
//   m0_req/addr -> m0_gnt     fetch request; m0_rvalid flags its response
//   m1_req/we/addr/wdata/be   load/store request; m1_gnt accepts it, m1_rvalid flags its
//                             response or write ack
//   m_rdata                   shared response data, qualified by mX_rvalid
//   s_req/we/addr/wdata/be    request to memory, muxed from the granted master
//   s_ready, s_rdata          memory accept and read data (data one cycle after accept)
//
// PRIO_MODE 0 = round-robin, 1 = fixed m0 priority. In mode 1, m1 is forced through after
// MAX_WAIT consecutive wait cycles. MAX_WAIT must be at least 1.
module mem_bus_arbiter #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned PRIO_MODE = 0,
    parameter int unsigned MAX_WAIT  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    // fetch master
    input  logic                m0_req,
    input  logic [ADDR_W-1:0]   m0_addr,
    output logic                m0_gnt,
    output logic                m0_rvalid,
    // load/store master
    input  logic                m1_req,
    input  logic                m1_we,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_be,
    output logic                m1_gnt,
    output logic                m1_rvalid,
    // shared response data
    output logic [DATA_W-1:0]   m_rdata,
    // memory side
    output logic                s_req,
    output logic                s_we,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_be,
    input  logic                s_ready,
    input  logic [DATA_W-1:0]   s_rdata
);

    localparam int unsigned CntW = $clog2(MAX_WAIT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MAX_WAIT);

    // Owner encoding: 0 = m0, 1 = m1.
    logic            last_owner_q, last_owner_d;
    logic            resp_pend_q, resp_pend_d;
    logic            resp_owner_q, resp_owner_d;
    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;

    logic            grant_m0, grant_m1;

    // Grant decision. rst_n is included so that the grants stay low during reset even
    // while requests are held.
    always_comb begin
        grant_m0 = 1'b0;
        grant_m1 = 1'b0;
        if (rst_n && s_ready) begin
            if (m0_req && m1_req) begin
                if (PRIO_MODE == 0) begin
                    // Round-robin: the master that did not win last time wins now.
                    if (last_owner_q) grant_m0 = 1'b1;
                    else              grant_m1 = 1'b1;
                end else begin
                    if (wait_cnt_q >= CntMax) grant_m1 = 1'b1;
                    else                      grant_m0 = 1'b1;
                end
            end else if (m0_req) begin
                grant_m0 = 1'b1;
            end else if (m1_req) begin
                grant_m1 = 1'b1;
            end
        end
    end

    assign m0_gnt = grant_m0;
    assign m1_gnt = grant_m1;

    // The memory-side mux. It holds zero when nothing is granted.
    always_comb begin
        s_req   = 1'b0;
        s_we    = 1'b0;
        s_addr  = '0;
        s_wdata = '0;
        s_be    = '0;
        if (grant_m0) begin
            s_req  = 1'b1;
            s_addr = m0_addr;
            s_be   = '1;
        end else if (grant_m1) begin
            s_req   = 1'b1;
            s_we    = m1_we;
            s_addr  = m1_addr;
            s_wdata = m1_wdata;
            s_be    = m1_be;
        end
    end

    // Next state. A stall (s_ready=0) leaves ownership and the counter untouched. A stall
    // still clears resp_pend, so the response of the previous cycle completes.
    always_comb begin
        resp_pend_d  = grant_m0 | grant_m1;
        resp_owner_d = resp_owner_q;
        last_owner_d = last_owner_q;
        wait_cnt_d   = wait_cnt_q;

        if (grant_m0 || grant_m1) begin
            resp_owner_d = grant_m1;
            last_owner_d = grant_m1;
        end

        if (!m1_req || grant_m1) begin
            wait_cnt_d = '0;
        end else if (s_ready && (wait_cnt_q < CntMax)) begin
            wait_cnt_d = wait_cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner_q <= 1'b1;  // m0 wins the first contended cycle
            resp_pend_q  <= 1'b0;
            resp_owner_q <= 1'b0;
            wait_cnt_q   <= '0;
        end else begin
            last_owner_q <= last_owner_d;
            resp_pend_q  <= resp_pend_d;
            resp_owner_q <= resp_owner_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    assign m0_rvalid = resp_pend_q & ~resp_owner_q;
    assign m1_rvalid = resp_pend_q &  resp_owner_q;
    assign m_rdata   = s_rdata;

endmodule
